add_seq_ctrl: RTL and testbench
===============================

ADD_SEQ_CTRL -- requirements
Module: add_seq_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 16, operand and result width.
REQ-002 SHALL have parameter: COMBINE_LOAD, 0, 1 = load A and B in one cycle.
REQ-003 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: req_valid  input  1  upstream request valid.
REQ-006 SHALL have port: req_ready  output  1  controller can accept a request.
REQ-007 SHALL have ports: req_a, req_b  input  WIDTH  operands; req_cin  input  1  carry-in.
REQ-008 SHALL have ports: d_a, d_b  output  WIDTH  operand data to the register-adder datapath.
REQ-009 SHALL have port: cin  output  1  carry-in to the datapath.
REQ-010 SHALL have ports: en_a, en_b, en_result  output  1  datapath register write strobes.
REQ-011 SHALL have ports: result  input  WIDTH and cout  input  1, both from the datapath.
REQ-012 SHALL have ports: rsp_valid  output  1 and rsp_ready  input  1  response handshake.
REQ-013 SHALL have ports: rsp_sum  output  WIDTH and rsp_cout  output  1  captured response.
REQ-014 SHALL have ports: busy  output  1 (state != IDLE) and txn_count  output  8  completed-transaction count.

Function
REQ-015 SHALL implement FSM IDLE -> LOAD_A -> LOAD_B -> STORE -> CAPTURE -> RESP -> IDLE.
REQ-016 SHALL drive req_ready=1 only in IDLE; accept on req_valid&req_ready and latch req_a, req_b, req_cin into internal operand registers.
REQ-017 SHALL drive d_a, d_b, cin from the latched registers, held constant from the accept edge until the next accept.
REQ-018 SHALL assert en_a for exactly the LOAD_A cycle and en_b for exactly the LOAD_B cycle.
REQ-019 SHALL, when COMBINE_LOAD=1, replace LOAD_A and LOAD_B with a single LOAD_AB cycle asserting en_a and en_b together.
REQ-020 SHALL assert en_result for exactly the STORE cycle; en_a, en_b and en_result SHALL be 0 in all other states.
REQ-021 SHALL sample result into rsp_sum and cout into rsp_cout at the end of the CAPTURE cycle.
REQ-022 SHALL assert rsp_valid throughout RESP only; rsp_sum/rsp_cout SHALL be stable while rsp_valid=1.
REQ-023 SHALL leave RESP for IDLE on rsp_valid&rsp_ready and increment txn_count (mod 256, 255 wraps to 0) on that edge.
REQ-024 SHALL hold RESP indefinitely while rsp_ready=0, with req_ready=0 and no datapath strobes.
REQ-025 SHALL give latency of 5 cycles (COMBINE_LOAD=0) or 4 cycles (COMBINE_LOAD=1) from accept edge to first rsp_valid=1 cycle.
REQ-026 SHALL have a minimum request spacing of one IDLE cycle after each response handshake; no accept in the RESP cycle.
REQ-027 SHALL pass overflow unchanged: sum wraps modulo 2^WIDTH with rsp_cout=1, with no special handling.
REQ-028 SHALL ignore req_valid and operand changes outside IDLE.

Reset
REQ-029 SHALL, with rst=1 at a rising edge, set state IDLE, en_a/en_b/en_result=0, rsp_valid=0, rsp_sum=0, rsp_cout=0, txn_count=0, operand registers=0 (d_a=d_b=0, cin=0).
REQ-030 SHALL, on reset mid-transaction, abort the transaction without a response or txn_count increment and drop strobes the cycle after the reset edge.
REQ-031 SHALL NOT reset the datapath; datapath registers keep their last written values across a controller reset.
REQ-032 SHALL make req_ready=1 in the first cycle after rst deasserts.

Verification
REQ-033 SHALL cover: request 100+50, cin=0, rsp_ready=1 -> en_a, en_b, en_result each high one cycle in order; rsp_sum=150, rsp_cout=0, txn_count=1.
REQ-034 SHALL cover: 65535+1, cin=0 -> rsp_sum=0, rsp_cout=1; 65535+0, cin=1 -> rsp_sum=0, rsp_cout=1.
REQ-035 SHALL cover: rsp_ready=0 for 10 cycles on 200+50 -> rsp_valid held, rsp_sum=250 stable, req_ready=0, no strobes; handshake then returns to IDLE.
REQ-036 SHALL cover: rst asserted during STORE -> no response, txn_count unchanged, all strobes 0 next cycle, req_ready=1 after release.
REQ-037 SHALL cover: COMBINE_LOAD=1, 1000+2000 -> en_a and en_b high in the same single cycle, rsp_valid at 4 cycles, rsp_sum=3000.
REQ-038 SHALL cover: 256 back-to-back transactions with rsp_ready=1 -> txn_count wraps to 0, every sum correct.

Source files
------------

// File: rtl/add_seq_ctrl.sv
// Sequencing controller for an external register-adder datapath.
// Accepts one add request at a time, steps the datapath through its register
// loads and its result store, and captures the sum. The sum is then held until
// the response handshake completes.
module add_seq_ctrl #(
    parameter int WIDTH        = 16,
    parameter int COMBINE_LOAD = 0
) (
    input  logic             clk,
    input  logic             rst,
    // request side
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             req_cin,
    // datapath side
    output logic [WIDTH-1:0] d_a,
    output logic [WIDTH-1:0] d_b,
    output logic             cin,
    output logic             en_a,
    output logic             en_b,
    output logic             en_result,
    input  logic [WIDTH-1:0] result,
    input  logic             cout,
    // response side
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    // status
    output logic             busy,
    output logic [7:0]       txn_count
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        LOAD_AB,
        STORE,
        CAPTURE,
        RESP
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             op_cin_q, op_cin_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             accept;
    logic             rsp_done;

    // Handshake qualifiers: requests are only taken in IDLE, responses only retire in RESP
    always_comb begin
        accept   = req_valid && (state_q == IDLE);
        rsp_done = rsp_ready && (state_q == RESP);
    end

    // Next-state logic; the combined-load variant skips straight to a single load cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (COMBINE_LOAD != 0) ? LOAD_AB : LOAD_A;
                end
            end
            LOAD_A:  state_d = LOAD_B;
            LOAD_B:  state_d = STORE;
            LOAD_AB: state_d = STORE;
            STORE:   state_d = CAPTURE;
            CAPTURE: state_d = RESP;
            RESP: begin
                if (rsp_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs decoded from the current state only
    always_comb begin
        req_ready = (state_q == IDLE);
        busy      = (state_q != IDLE);
        en_a      = (state_q == LOAD_A) || (state_q == LOAD_AB);
        en_b      = (state_q == LOAD_B) || (state_q == LOAD_AB);
        en_result = (state_q == STORE);
        rsp_valid = (state_q == RESP);
    end

    // Operand latch on accept, sum capture at the end of CAPTURE, count on response retire
    always_comb begin
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        op_cin_d = op_cin_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        cnt_d    = cnt_q;
        if (accept) begin
            op_a_d   = req_a;
            op_b_d   = req_b;
            op_cin_d = req_cin;
        end
        if (state_q == CAPTURE) begin
            sum_d  = result;
            cout_d = cout;
        end
        if (rsp_done) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // State and data registers; reset aborts any transaction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            op_cin_q <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            op_cin_q <= op_cin_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            cnt_q    <= cnt_d;
        end
    end

    assign d_a       = op_a_q;
    assign d_b       = op_b_q;
    assign cin       = op_cin_q;
    assign rsp_sum   = sum_q;
    assign rsp_cout  = cout_q;
    assign txn_count = cnt_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Bench for add_seq_ctrl: two instances (separate and combined load), each
// paired with a behavioural register-adder datapath.
module tb_add_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---- instance with separate loads ----
    logic        req_valid = 1'b0, req_ready, req_cin = 1'b0;
    logic [15:0] req_a = '0, req_b = '0, d_a, d_b, result, rsp_sum;
    logic        cin, en_a, en_b, en_result, cout, rsp_valid, rsp_ready = 1'b1, rsp_cout, busy;
    logic [7:0]  txn_count;

    add_seq_ctrl #(.WIDTH(16), .COMBINE_LOAD(0)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .d_a(d_a), .d_b(d_b), .cin(cin),
        .en_a(en_a), .en_b(en_b), .en_result(en_result),
        .result(result), .cout(cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
        .busy(busy), .txn_count(txn_count)
    );

    // ---- instance with combined load ----
    logic        c_req_valid = 1'b0, c_req_ready, c_req_cin = 1'b0;
    logic [15:0] c_req_a = '0, c_req_b = '0, c_d_a, c_d_b, c_result, c_rsp_sum;
    logic        c_cin, c_en_a, c_en_b, c_en_result, c_cout, c_rsp_valid, c_rsp_ready = 1'b1;
    logic        c_rsp_cout, c_busy;
    logic [7:0]  c_txn_count;

    add_seq_ctrl #(.WIDTH(16), .COMBINE_LOAD(1)) dut_c (
        .clk(clk), .rst(rst),
        .req_valid(c_req_valid), .req_ready(c_req_ready),
        .req_a(c_req_a), .req_b(c_req_b), .req_cin(c_req_cin),
        .d_a(c_d_a), .d_b(c_d_b), .cin(c_cin),
        .en_a(c_en_a), .en_b(c_en_b), .en_result(c_en_result),
        .result(c_result), .cout(c_cout),
        .rsp_valid(c_rsp_valid), .rsp_ready(c_rsp_ready),
        .rsp_sum(c_rsp_sum), .rsp_cout(c_rsp_cout),
        .busy(c_busy), .txn_count(c_txn_count)
    );

    // Behavioural datapaths (never reset)
    logic [15:0] dp_a = '0, dp_b = '0, cdp_a = '0, cdp_b = '0;
    logic [16:0] dp_r = '0, cdp_r = '0;
    always @(posedge clk) begin
        if (en_a)      dp_a <= d_a;
        if (en_b)      dp_b <= d_b;
        if (en_result) dp_r <= {1'b0, dp_a} + {1'b0, dp_b} + {16'd0, cin};
        if (c_en_a)      cdp_a <= c_d_a;
        if (c_en_b)      cdp_b <= c_d_b;
        if (c_en_result) cdp_r <= {1'b0, cdp_a} + {1'b0, cdp_b} + {16'd0, c_cin};
    end
    assign result   = dp_r[15:0];
    assign cout     = dp_r[16];
    assign c_result = cdp_r[15:0];
    assign c_cout   = cdp_r[16];

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_cnt = 8'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // One full transaction on the separate-load instance; hold = RESP cycles with rsp_ready=0
    task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input logic ci,
                           input int hold, input logic [15:0] es, input logic ec, input string nm);
        int cyc;
        logic [7:0] t_a, t_b, t_r, n_a, n_b, n_r;
        t_a = 0; t_b = 0; t_r = 0; n_a = 0; n_b = 0; n_r = 0;
        @(negedge clk);
        chk({nm, ":req_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_a = a; req_b = b; req_cin = ci;
        rsp_ready = (hold == 0);
        @(negedge clk);
        // keep valid high with junk operands: must be ignored outside IDLE
        req_a = ~a; req_b = a ^ b ^ 16'h5a5a; req_cin = ~ci;
        cyc = 1;
        while (!rsp_valid && cyc < 20) begin
            if (en_a)      begin n_a++; t_a = cyc[7:0]; end
            if (en_b)      begin n_b++; t_b = cyc[7:0]; end
            if (en_result) begin n_r++; t_r = cyc[7:0]; end
            @(negedge clk);
            cyc++;
        end
        req_valid = 1'b0;
        chk({nm, ":latency"}, cyc, 32'd5);
        chk({nm, ":strobe_cycles"}, {8'd0, t_a, t_b, t_r}, 32'h00010203);
        chk({nm, ":strobe_counts"}, {8'd0, n_a, n_b, n_r}, 32'h00010101);
        chk({nm, ":sum"}, {15'd0, rsp_cout, rsp_sum}, {15'd0, ec, es});
        chk({nm, ":operands"}, {d_a, d_b}, {a, b});
        chk({nm, ":cin"}, {31'd0, cin}, {31'd0, ci});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({nm, ":hold"}, {10'd0, rsp_valid, req_ready, en_a, en_b, en_result, rsp_cout, rsp_sum},
                {10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ec, es});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        exp_cnt = exp_cnt + 8'd1;
        chk({nm, ":post_hs"}, {29'd0, rsp_valid, req_ready, busy}, 32'b010);
        chk({nm, ":txn_count"}, {24'd0, txn_count}, {24'd0, exp_cnt});
        $display("txn %s a=%0d b=%0d cin=%0d sum=%0d cout=%0d count=%0d",
                 nm, a, b, ci, rsp_sum, rsp_cout, txn_count);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        int          hold;
        logic [15:0] es;
        logic        ec;
        string       nm;
    } vec_t;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[8];
        int cyc;
        logic [7:0] t_ab, t_r, n_a, n_b, n_r;
        logic [16:0] full;
        logic [15:0] ra, rb;
        logic rc;

        vecs[0] = '{16'd100,   16'd50,    1'b0, 0,  16'd150,   1'b0, "add_100_50"};
        vecs[1] = '{16'd65535, 16'd1,     1'b0, 0,  16'd0,     1'b1, "ovf_ffff_1"};
        vecs[2] = '{16'd65535, 16'd0,     1'b1, 0,  16'd0,     1'b1, "ovf_ffff_cin"};
        vecs[3] = '{16'd200,   16'd50,    1'b0, 10, 16'd250,   1'b0, "backpressure"};
        vecs[4] = '{16'd1234,  16'd4321,  1'b1, 0,  16'd5556,  1'b0, "add_cin"};
        vecs[5] = '{16'd32768, 16'd32768, 1'b0, 0,  16'd0,     1'b1, "msb_ovf"};
        vecs[6] = '{16'd0,     16'd0,     1'b0, 2,  16'd0,     1'b0, "zero"};
        vecs[7] = '{16'd65535, 16'd65535, 1'b1, 0,  16'd65535, 1'b1, "max_all"};

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset:outputs", {25'd0, en_a, en_b, en_result, rsp_valid, rsp_cout, busy, req_ready},
            32'd1);
        chk("reset:data", {rsp_sum, d_a}, 32'd0);
        chk("reset:d_b_cin_count", {7'd0, cin, d_b, txn_count}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset:ready_after", {31'd0, req_ready}, 32'd1);

        // Reset during STORE aborts the transaction
        req_valid = 1'b1; req_a = 16'd7; req_b = 16'd9; req_cin = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort:in_store", {29'd0, en_a, en_b, en_result}, 32'b001);
        rst = 1'b1;
        @(negedge clk);
        chk("abort:strobes", {27'd0, en_a, en_b, en_result, rsp_valid, busy}, 32'd0);
        chk("abort:operands", {7'd0, cin, d_a, txn_count}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort:ready", {30'd0, req_ready, rsp_valid}, 32'b10);
        repeat (5) begin
            @(negedge clk);
            chk("abort:no_rsp", {23'd0, rsp_valid, txn_count}, 32'd0);
        end
        $display("txn abort_in_store count=%0d", txn_count);

        // Table-driven transactions
        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].hold, vecs[i].es, vecs[i].ec, vecs[i].nm);
        end

        // Combined-load instance: 1000 + 2000
        @(negedge clk);
        chk("comb:req_ready", {31'd0, c_req_ready}, 32'd1);
        c_req_valid = 1'b1; c_req_a = 16'd1000; c_req_b = 16'd2000; c_req_cin = 1'b0;
        c_rsp_ready = 1'b1;
        @(negedge clk);
        c_req_valid = 1'b0;
        t_ab = 0; t_r = 0; n_a = 0; n_b = 0; n_r = 0;
        cyc = 1;
        while (!c_rsp_valid && cyc < 20) begin
            if (c_en_a && c_en_b) t_ab = cyc[7:0];
            if (c_en_a)      n_a++;
            if (c_en_b)      n_b++;
            if (c_en_result) begin n_r++; t_r = cyc[7:0]; end
            @(negedge clk);
            cyc++;
        end
        chk("comb:latency", cyc, 32'd4);
        chk("comb:strobe_cycles", {16'd0, t_ab, t_r}, 32'h0102);
        chk("comb:strobe_counts", {8'd0, n_a, n_b, n_r}, 32'h00010101);
        chk("comb:sum", {15'd0, c_rsp_cout, c_rsp_sum}, 32'd3000);
        @(negedge clk);
        chk("comb:txn_count", {23'd0, c_rsp_valid, c_txn_count}, 32'd1);
        $display("txn comb_1000_2000 sum=%0d count=%0d", c_rsp_sum, c_txn_count);

        // 256 back-to-back transactions from a clean count: wraps to 0
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 8'd0;
        for (int i = 0; i < 256; i++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            rc = 1'($urandom_range(0, 1));
            full = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
            run_txn(ra, rb, rc, 0, full[15:0], full[16], $sformatf("wrap%0d", i));
        end
        chk("wrap:txn_count_zero", {24'd0, txn_count}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
